// File: rtl/wb_hp_poller.sv
// wb_hp_poller: Wishbone pipelined-mode initiator that services the hp status/control
// register of the hardware-protection responder without CPU involvement.
//
// It reads the register every POLL_CYCLES idle cycles. When Alarm_latch (bit 5) is set,
// it captures Alarm_ctr, pulses alarm_evt and then clears the latch. Clearing is done by
// writing Alarm_rst|Alarm_ctr_rst (with vcc), waiting HOLD_CYCLES, then writing vcc alone.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   enable                poller runs while high
//   vcc_en                value driven onto hp_vcc (bit 0) in every write
//   o_wb_cyc/stb/we       Wishbone initiator controls
//   o_wb_addr/o_wb_data   HP_ADDR during a cycle, else 0; write data, 0 unless writing
//   i_wb_ack/stall/data   responder ack, stall and read data
//   alarm_evt             one-cycle pulse per serviced latch event
//   last_ctr              Alarm_ctr captured at the last serviced event
//   evt_count             serviced events, saturating
//   status                last read data word
//   bus_err               sticky ack-timeout flag, cleared only by reset
//   busy                  high whenever the FSM is not idle
module wb_hp_poller #(
  parameter logic [31:0] HP_ADDR     = 32'h3000_0000,
  parameter int unsigned POLL_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vcc_en,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic        alarm_evt,
  output logic [7:0]  last_ctr,
  output logic [15:0] evt_count,
  output logic [31:0] status,
  output logic        bus_err,
  output logic        busy
);

  localparam int unsigned CntMax = (POLL_CYCLES > HOLD_CYCLES) ? POLL_CYCLES : HOLD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] PollLoad = CntW'(POLL_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRd,
    StEval,
    StWrSet,
    StHold,
    StWrClr
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       status_q, status_d;
  logic [7:0]        last_ctr_q, last_ctr_d;
  logic [15:0]       evt_count_q, evt_count_d;
  logic              bus_err_q, bus_err_d;

  logic              in_bus_state;
  logic              txn_done;
  logic              txn_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= '0;
      status_q    <= '0;
      last_ctr_q  <= '0;
      evt_count_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      data_q      <= data_d;
      status_q    <= status_d;
      last_ctr_q  <= last_ctr_d;
      evt_count_q <= evt_count_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    data_d      = data_q;
    status_d    = status_q;
    last_ctr_d  = last_ctr_q;
    evt_count_d = evt_count_q;
    bus_err_d   = bus_err_q;
    txn_done    = 1'b0;
    txn_tmo     = 1'b0;

    in_bus_state = (state_q == StRd) || (state_q == StWrSet) || (state_q == StWrClr);

    // Shared single-outstanding transaction engine. While stb is up an ack cannot belong
    // to us unless this same edge also accepts the request.
    if (in_bus_state) begin
      if (stb_q) begin
        if (!i_wb_stall) begin
          stb_d = 1'b0;
          tmo_d = '0;
          if (i_wb_ack) begin
            txn_done = 1'b1;
          end
        end
      end else if (i_wb_ack) begin
        txn_done = 1'b1;
      end else if (tmo_q == TmoLast) begin
        txn_tmo = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end

      if (txn_done || txn_tmo) begin
        cyc_d  = 1'b0;
        we_d   = 1'b0;
        data_d = '0;
      end
      if (txn_tmo) begin
        bus_err_d = 1'b1;
        state_d   = StIdle;
      end
    end

    case (state_q)
      StIdle: begin
        if (enable && !bus_err_q) begin
          state_d = StWait;
          cnt_d   = PollLoad;
        end
      end

      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StRd;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StRd: begin
        if (txn_done) begin
          status_d = i_wb_data;
          state_d  = StEval;
        end
      end

      StEval: begin
        if (status_q[5]) begin
          last_ctr_d = status_q[15:8];
          if (evt_count_q != 16'hFFFF) begin
            evt_count_d = evt_count_q + 16'd1;
          end
          // Assert Alarm_rst and Alarm_ctr_rst; vcc_en is frozen here for the whole write.
          state_d = StWrSet;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          data_d  = {29'b0, 1'b1, 1'b1, vcc_en};
        end else if (enable) begin
          state_d = StWait;
          cnt_d   = PollLoad;
        end else begin
          state_d = StIdle;
        end
      end

      StWrSet: begin
        if (txn_done) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end

      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWrClr;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          data_d  = {31'b0, vcc_en};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StWrClr: begin
        if (txn_done) begin
          if (enable) begin
            state_d = StWait;
            cnt_d   = PollLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = cyc_q ? HP_ADDR : 32'h0;
  assign o_wb_data = data_q;

  // The event pulse is the EVAL cycle that found a latched alarm.
  assign alarm_evt = (state_q == StEval) && status_q[5];
  assign last_ctr  = last_ctr_q;
  assign evt_count = evt_count_q;
  assign status    = status_q;
  assign bus_err   = bus_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_wb_hp_poller.sv
// Directed bench for wb_hp_poller: the bench plays the Wishbone responder by hand and
// checks bus timing, captured data, event bookkeeping, timeout and reset behaviour.
module tb_wb_hp_poller;

  localparam int unsigned P = 16;
  localparam int unsigned H = 10;
  localparam int unsigned T = 255;
  localparam logic [31:0] Addr = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        vcc_en;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        alarm_evt;
  logic [7:0]  last_ctr;
  logic [15:0] evt_count;
  logic [31:0] status;
  logic        bus_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int evt_pulses = 0;

  wb_hp_poller #(
    .HP_ADDR    (Addr),
    .POLL_CYCLES(P),
    .HOLD_CYCLES(H),
    .TIMEOUT    (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .vcc_en    (vcc_en),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .i_wb_ack  (ack),
    .i_wb_stall(stall),
    .i_wb_data (rdata),
    .alarm_evt (alarm_evt),
    .last_ctr  (last_ctr),
    .evt_count (evt_count),
    .status    (status),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; look a little later to see what the DUT will sample.
  always @(negedge clk) begin
    #2;
    if (o_wb_stb && !stall) acc_cnt++;
    if (alarm_evt) evt_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input string tag, output int gap);
    gap = 0;
    while (!o_wb_stb && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, "/stb_seen"}, 32'(o_wb_stb), 32'd1);
  endtask

  // Called at a falling edge with stb high: stall, accept, then ack.
  task automatic finish_txn(input string tag, input int stall_n, input bit same_ack,
                            input logic [31:0] rd);
    logic [31:0] d0;
    d0 = o_wb_data;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(negedge clk);
      chk({tag, "/stall_stb"}, 32'(o_wb_stb), 32'd1);
      chk({tag, "/stall_data"}, o_wb_data, d0);
    end
    stall = 1'b0;
    if (same_ack) begin
      ack   = 1'b1;
      rdata = rd;
    end
    @(negedge clk);
    chk({tag, "/stb_drop"}, 32'(o_wb_stb), 32'd0);
    if (same_ack) begin
      ack = 1'b0;
    end else begin
      chk({tag, "/cyc_hold"}, 32'(o_wb_cyc), 32'd1);
      ack   = 1'b1;
      rdata = rd;
      @(negedge clk);
      ack = 1'b0;
    end
    chk({tag, "/cyc_drop"}, 32'(o_wb_cyc), 32'd0);
  endtask

  initial begin
    int gap;
    int a0;
    int n;

    reset  = 1'b1;
    enable = 1'b0;
    vcc_en = 1'b1;
    ack    = 1'b0;
    stall  = 1'b0;
    rdata  = '0;

    #12;
    chk("rst/ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, busy, bus_err, alarm_evt}), 32'd0);
    chk("rst/addr", o_wb_addr, 32'h0);
    chk("rst/data", o_wb_data, 32'h0);
    chk("rst/cnt", 32'({last_ctr, evt_count}), 32'd0);
    chk("rst/status", status, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("disabled/busy", 32'(busy), 32'd0);

    // Plain poll, no alarm.
    enable = 1'b1;
    wait_stb("poll1", gap);
    chk("poll1/gap", 32'(gap), 32'(P + 1));
    chk("poll1/addr", o_wb_addr, Addr);
    chk("poll1/we", 32'(o_wb_we), 32'd0);
    chk("poll1/data", o_wb_data, 32'h0);
    chk("poll1/busy", 32'(busy), 32'd1);
    finish_txn("poll1", 0, 1'b0, 32'h0000_0001);
    chk("poll1/status", status, 32'h0000_0001);
    chk("poll1/evt", 32'(alarm_evt), 32'd0);

    // Stalled read: one acceptance only, data captured.
    wait_stb("stall", gap);
    chk("stall/gap", 32'(gap), 32'(P + 1));
    a0 = acc_cnt;
    finish_txn("stall", 5, 1'b0, 32'h0000_5A11);
    chk("stall/status", status, 32'h0000_5A11);
    @(negedge clk);
    chk("stall/accepts", 32'(acc_cnt - a0), 32'd1);

    // Ack on the acceptance edge.
    wait_stb("same_ack", gap);
    chk("same_ack/gap", 32'(gap), 32'(P));
    finish_txn("same_ack", 0, 1'b1, 32'h0000_0001);
    chk("same_ack/status", status, 32'h0000_0001);

    // Latched alarm and clear sequence.
    wait_stb("alarm", gap);
    chk("alarm/gap", 32'(gap), 32'(P + 1));
    finish_txn("alarm", 0, 1'b0, 32'h0000_0331);
    chk("alarm/evt_hi", 32'(alarm_evt), 32'd1);
    @(negedge clk);
    chk("alarm/evt_lo", 32'(alarm_evt), 32'd0);
    chk("alarm/last_ctr", 32'(last_ctr), 32'd3);
    chk("alarm/evt_count", 32'(evt_count), 32'd1);
    wait_stb("wr_set", gap);
    chk("wr_set/gap", 32'(gap), 32'd0);
    chk("wr_set/we", 32'(o_wb_we), 32'd1);
    chk("wr_set/data", o_wb_data, 32'h7);
    chk("wr_set/addr", o_wb_addr, Addr);
    finish_txn("wr_set", 1, 1'b0, 32'h0);
    wait_stb("wr_clr", gap);
    chk("wr_clr/gap", 32'(gap), 32'(H));
    chk("wr_clr/we", 32'(o_wb_we), 32'd1);
    chk("wr_clr/data", o_wb_data, 32'h1);
    vcc_en = 1'b0;  // must not disturb the write already launched
    finish_txn("wr_clr", 2, 1'b0, 32'h0);
    vcc_en = 1'b1;
    wait_stb("post", gap);
    chk("post/gap", 32'(gap), 32'(P));
    chk("post/we", 32'(o_wb_we), 32'd0);
    finish_txn("post", 0, 1'b0, 32'h0000_0001);
    @(negedge clk);
    chk("post/pulses", 32'(evt_pulses), 32'd1);
    chk("post/evt_count", 32'(evt_count), 32'd1);

    // Ack never arrives.
    wait_stb("tmo", gap);
    @(negedge clk);
    chk("tmo/stb_drop", 32'(o_wb_stb), 32'd0);
    n = 0;
    while (o_wb_cyc && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo/cycles", 32'(n), 32'(T));
    chk("tmo/bus_err", 32'(bus_err), 32'd1);
    chk("tmo/busy", 32'(busy), 32'd0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_wb_cyc) n++;
    end
    chk("tmo/quiet", 32'(n), 32'd0);

    // Reset clears bus_err and polling resumes.
    #3 reset = 1'b1;
    #1 chk("tmo_rst/bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    vcc_en = 1'b0;
    wait_stb("resume", gap);
    chk("resume/gap", 32'(gap), 32'(P + 1));
    chk("resume/we", 32'(o_wb_we), 32'd0);
    finish_txn("resume", 0, 1'b0, 32'h0000_0331);
    wait_stb("wr_set0", gap);
    chk("wr_set0/data", o_wb_data, 32'h6);
    stall = 1'b1;
    @(negedge clk);
    chk("wr_set0/stb", 32'(o_wb_stb), 32'd1);

    // Reset in the middle of the write.
    #3 reset = 1'b1;
    #1;
    chk("midrst/ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, alarm_evt}), 32'd0);
    chk("midrst/addr", o_wb_addr, 32'h0);
    chk("midrst/data", o_wb_data, 32'h0);
    chk("midrst/evt_count", 32'(evt_count), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_stb("restart", gap);
    chk("restart/gap", 32'(gap), 32'(P + 1));
    chk("restart/we", 32'(o_wb_we), 32'd0);
    chk("restart/data", o_wb_data, 32'h0);
    finish_txn("restart", 0, 1'b0, 32'h0000_0001);
    chk("restart/status", status, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
